// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: state encodings and register-address constants shared by the hazard controller
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MDIV_WAIT = 2'd1
  } state_e;
  localparam logic [4:0] X0_ADDR = 5'd0;
endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// load_use_detect: flags an ID-stage read of a register an EX-stage load is about to write
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_mem_read,
  output logic       load_use
);
  assign load_use = ex_mem_read && (ex_rd_addr != X0_ADDR) &&
                    ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline; HAZARD_PERF_EN adds perf counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MDIV_MAX_LAT = 34,
  parameter int CNT_W        = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        ex_mdiv_start,
  input  logic        mdiv_done,
  input  logic        mem_stall,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        if_id_flush,
  output logic        id_ex_enable,
  output logic        id_ex_flush,
  output logic        ex_mem_enable,
  output logic        ex_mem_flush,
  output logic        mdiv_busy,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_events,
`endif
  output logic        mdiv_timeout
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               load_use;
  logic               mdiv_release;

  load_use_detect u_lud (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd_addr  (ex_rd_addr),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mdiv_release = mdiv_done || (cnt_q == CNT_W'(MDIV_MAX_LAT - 1));
  assign mdiv_busy    = (state_q == ST_MDIV_WAIT);
  assign mdiv_timeout = timeout_q;

  // Next state and stage controls, resolved in priority order: reset, mem_stall, M-unit, redirect, load-use
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_enable = 1'b1;
    ex_mem_flush  = 1'b0;
    if (!rst || mem_stall) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
    end else if (state_q == ST_MDIV_WAIT) begin
      if (mdiv_release) begin
        state_d   = ST_RUN;
        cnt_d     = '0;
        timeout_d = timeout_q || !mdiv_done;
      end else begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_enable = 1'b0;
        ex_mem_flush = 1'b1;
        cnt_d        = cnt_q + CNT_W'(1);
      end
    end else if (ex_mdiv_start) begin
      if (!mdiv_done) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_enable = 1'b0;
        ex_mem_flush = 1'b1;
        state_d      = ST_MDIV_WAIT;
        cnt_d        = CNT_W'(1);
      end
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  // FSM state, M-unit watchdog and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_EN
  // Free-running stall-cycle and redirect-flush counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
    end else begin
      if (!pc_enable) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (if_id_flush) perf_flush_events <= perf_flush_events + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table-driven and sequence checks of pipeline_hazard_ctrl with a scoreboard queue
module tb_pipeline_hazard_ctrl;
  localparam logic [8:0] EN   = 9'b110101000;
  localparam logic [8:0] ZERO = 9'b000000000;
  localparam logic [8:0] LU   = 9'b000111000;
  localparam logic [8:0] RD   = 9'b111111000;
  localparam logic [8:0] MDH  = 9'b000001100;
  localparam logic [8:0] MDW  = 9'b000001110;
  localparam logic [8:0] REL  = 9'b110101010;
  localparam logic [8:0] BUSY = 9'b000000010;
  localparam logic [8:0] TO   = 9'b000000001;

  typedef struct {
    string      name;
    logic       rstn, ms, st, dn, rdr, mr;
    logic [4:0] exrd, rs1, rs2;
    logic       u1, u2;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, mem_stall, ex_mdiv_start, mdiv_done, ex_redirect, ex_mem_read;
  logic [4:0] ex_rd_addr, id_rs1_addr, id_rs2_addr;
  logic id_rs1_used, id_rs2_used;
  logic pc_a, ifen_a, iffl_a, idexen_a, idexfl_a, exen_a, exfl_a, busy_a, to_a;
  logic pc_b, ifen_b, iffl_b, idexen_b, idexfl_b, exen_b, exfl_b, busy_b, to_b;
  logic [8:0] outa, outb;
  logic use_b = 1'b0;
  int passed = 0;
  int total = 0;
  logic [8:0] exp_q[$];
  string nm_q[$];
  vec_t tbl[15];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_mdiv_start(ex_mdiv_start),
    .mdiv_done(mdiv_done), .mem_stall(mem_stall), .pc_enable(pc_a), .if_id_enable(ifen_a),
    .if_id_flush(iffl_a), .id_ex_enable(idexen_a), .id_ex_flush(idexfl_a),
    .ex_mem_enable(exen_a), .ex_mem_flush(exfl_a), .mdiv_busy(busy_a), .mdiv_timeout(to_a)
  );

  pipeline_hazard_ctrl #(.MDIV_MAX_LAT(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_mdiv_start(ex_mdiv_start),
    .mdiv_done(mdiv_done), .mem_stall(mem_stall), .pc_enable(pc_b), .if_id_enable(ifen_b),
    .if_id_flush(iffl_b), .id_ex_enable(idexen_b), .id_ex_flush(idexfl_b),
    .ex_mem_enable(exen_b), .ex_mem_flush(exfl_b), .mdiv_busy(busy_b), .mdiv_timeout(to_b)
  );

  assign outa = {pc_a, ifen_a, iffl_a, idexen_a, idexfl_a, exen_a, exfl_a, busy_a, to_a};
  assign outb = {pc_b, ifen_b, iffl_b, idexen_b, idexfl_b, exen_b, exfl_b, busy_b, to_b};

  function automatic vec_t mk(string n, logic [8:0] e, logic rstn, logic ms, logic st, logic dn,
                              logic rdr, logic mr, logic [4:0] exrd, logic [4:0] rs1,
                              logic [4:0] rs2, logic u1, logic u2);
    vec_t v;
    v.name = n; v.exp = e; v.rstn = rstn; v.ms = ms; v.st = st; v.dn = dn; v.rdr = rdr;
    v.mr = mr; v.exrd = exrd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    return v;
  endfunction

  function automatic vec_t idle(string n, logic [8:0] e);
    return mk(n, e, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t mdiv(string n, logic [8:0] e, logic ms, logic dn);
    return mk(n, e, 1, ms, 1, dn, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply(input vec_t v);
    logic [8:0] got, e;
    string n;
    @(posedge clk);
    #1;
    rst = v.rstn; mem_stall = v.ms; ex_mdiv_start = v.st; mdiv_done = v.dn;
    ex_redirect = v.rdr; ex_mem_read = v.mr; ex_rd_addr = v.exrd;
    id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    exp_q.push_back(v.exp);
    nm_q.push_back(v.name);
    @(negedge clk);
    got = use_b ? outb : outa;
    e = exp_q.pop_front();
    n = nm_q.pop_front();
    total++;
    if (got === e) passed++;
    else $display("FAIL %s: got %b expected %b", n, got, e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0]  = idle("idle", EN);
    tbl[1]  = mk("lu_rs2", LU, 1, 0, 0, 0, 0, 1, 5, 3, 5, 1, 1);
    tbl[2]  = idle("after_lu", EN);
    tbl[3]  = mk("lu_rs1", LU, 1, 0, 0, 0, 0, 1, 7, 7, 2, 1, 0);
    tbl[4]  = mk("lu_unused", EN, 1, 0, 0, 0, 0, 1, 7, 7, 7, 0, 0);
    tbl[5]  = mk("x0_load", EN, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    tbl[6]  = mk("no_load", EN, 1, 0, 0, 0, 0, 0, 5, 5, 5, 1, 1);
    tbl[7]  = mk("redirect", RD, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = idle("after_redirect", EN);
    tbl[9]  = mk("redirect_over_lu", RD, 1, 0, 0, 0, 1, 1, 5, 5, 0, 1, 0);
    tbl[10] = mk("mem_stall", ZERO, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk("mem_stall_over_lu", ZERO, 1, 1, 0, 0, 1, 1, 5, 5, 0, 1, 0);
    tbl[12] = mk("mul_single", EN, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk("mul_ignores_redirect", EN, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk("lu_mismatch", EN, 1, 0, 0, 0, 0, 1, 5, 6, 4, 1, 1);
    apply(mk("reset0", ZERO, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("reset1", ZERO, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++) apply(tbl[i]);
    apply(mdiv("div_start", MDH, 0, 0));
    for (int i = 0; i < 31; i++) apply(mdiv($sformatf("div_wait%0d", i), MDW, 0, 0));
    apply(mdiv("div_release", REL, 0, 1));
    apply(idle("div_after", EN));
    apply(mk("rst_before_wd", ZERO, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    use_b = 1'b1;
    apply(idle("wd_idle", EN));
    apply(mdiv("wd_start", MDH, 0, 0));
    apply(mdiv("wd_wait1", MDW, 0, 0));
    apply(mdiv("wd_wait2", MDW, 0, 0));
    apply(mdiv("wd_release", REL, 0, 0));
    apply(idle("wd_sticky1", EN | TO));
    apply(mdiv("wd_sticky_mul", EN | TO, 0, 1));
    apply(mk("wd_rst", TO, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(idle("wd_cleared", EN));
    use_b = 1'b0;
    apply(mdiv("ms_start", MDH, 0, 0));
    apply(mdiv("ms_wait", MDW, 0, 0));
    apply(mdiv("ms_hold_done0", BUSY, 1, 1));
    apply(mdiv("ms_hold_done1", BUSY, 1, 1));
    apply(mdiv("ms_release", REL, 0, 1));
    apply(idle("ms_after", EN));
    apply(mdiv("rw_start", MDH, 0, 0));
    apply(mdiv("rw_wait", MDW, 0, 0));
    apply(mk("rw_rst", BUSY, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(idle("rw_run", EN));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
